// File: rtl/ccff_pkg.sv
// Shared types and width helpers for the CCFF configuration-chain writer.
// Imported by the serializer and the writer top.
package ccff_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } ccff_wr_state_e;

    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int idx_width(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/ccff_bitstream_writer_if.sv
// Valid/ready word stream feeding the CCFF writer.
// master drives words; slave (the writer) returns ready.
interface ccff_bitstream_writer_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;

    modport master (
        output word_data,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_data,
        input  word_valid,
        output word_ready
    );
endinterface

// File: rtl/ccff_serializer.sv
// Holds one configuration word and emits it LSB first as
// registered head/shift-enable pairs for the CCFF chain.
module ccff_serializer
    import ccff_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture,
    input  logic              shift,
    input  logic [WORD_W-1:0] data,
    output logic              last,
    output logic              head,
    output logic              shift_en
);
    localparam int IDX_W = idx_width(WORD_W);

    logic [WORD_W-1:0] hold_q;
    logic [IDX_W-1:0]  bit_idx;

    assign last = (bit_idx == IDX_W'(WORD_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q   <= '0;
            bit_idx  <= '0;
            head     <= 1'b0;
            shift_en <= 1'b0;
        end else begin
            if (capture) begin
                hold_q  <= data;
                bit_idx <= '0;
            end else if (shift) begin
                bit_idx <= bit_idx + 1'b1;
            end
            if (shift) begin
                head <= hold_q[bit_idx];
            end
            shift_en <= shift;
        end
    end
endmodule

// File: rtl/ccff_bitstream_writer.sv
// Writer end of the CCFF chain: takes words over valid/ready, shifts
// exactly CHAIN_LEN bits into ccff_head and returns the tail as readback.
module ccff_bitstream_writer
    import ccff_pkg::*;
#(
    parameter int CHAIN_LEN = 5,
    parameter int WORD_W    = 8
) (
    input  logic                     prog_clk,
    input  logic                     prog_rst_n,
    input  logic                     start,
    input  logic                     abort,
    ccff_bitstream_writer_if.slave   word,
    output logic                     ccff_head,
    output logic                     ccff_shift_en,
    input  logic                     ccff_tail,
    output logic                     rb_bit,
    output logic                     rb_valid,
    output logic                     busy,
    output logic                     done
);
    localparam int CNT_W = cnt_width(CHAIN_LEN);

    ccff_wr_state_e   state;
    ccff_wr_state_e   state_n;
    logic [CNT_W-1:0] shift_cnt;
    logic             cnt_last;
    logic             word_last;
    logic             do_cap;
    logic             do_shift;
    logic             do_clear;

    assign cnt_last        = (shift_cnt == CNT_W'(CHAIN_LEN - 1));
    assign word.word_ready = (state == LOAD);

    always_comb begin
        state_n  = state;
        do_cap   = 1'b0;
        do_shift = 1'b0;
        do_clear = 1'b0;
        if (abort) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state_n  = LOAD;
                        do_clear = 1'b1;
                    end
                end
                LOAD: begin
                    if (word.word_valid) begin
                        do_cap  = 1'b1;
                        state_n = SHIFT;
                    end
                end
                SHIFT: begin
                    do_shift = 1'b1;
                    // chain length, not word length, ends the load
                    if (cnt_last) begin
                        state_n = DONE;
                    end else if (word_last) begin
                        state_n = LOAD;
                    end
                end
                DONE: state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            state     <= IDLE;
            shift_cnt <= '0;
            rb_bit    <= 1'b0;
            rb_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= state_n;
            if (do_clear) begin
                shift_cnt <= '0;
            end else if (do_shift) begin
                shift_cnt <= shift_cnt + 1'b1;
            end
            if (ccff_shift_en) begin
                rb_bit <= ccff_tail;
            end
            rb_valid <= ccff_shift_en;
            busy     <= (state_n != IDLE);
            done     <= (state == DONE) && !abort;
        end
    end

    ccff_serializer #(
        .WORD_W (WORD_W)
    ) u_ser (
        .clk      (prog_clk),
        .rst_n    (prog_rst_n),
        .capture  (do_cap),
        .shift    (do_shift),
        .data     (word.word_data),
        .last     (word_last),
        .head     (ccff_head),
        .shift_en (ccff_shift_en)
    );
endmodule

// File: tb/tb_ccff_bitstream_writer.sv
// Bench for the CCFF writer: a 5-bit and a 20-bit chain model with a
// readback scoreboard of the displaced old chain contents.
module tb_ccff_bitstream_writer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] start_s, abort_s, head_s, en_s, tail_s;
    logic [1:0] rbb_s, rbv_s, busy_s, done_s, valid_s, ready_s;
    logic [7:0] data_s [2];

    ccff_bitstream_writer_if #(.WORD_W(8)) wif0 ();
    ccff_bitstream_writer_if #(.WORD_W(8)) wif1 ();

    assign wif0.word_data  = data_s[0];
    assign wif0.word_valid = valid_s[0];
    assign ready_s[0]      = wif0.word_ready;
    assign wif1.word_data  = data_s[1];
    assign wif1.word_valid = valid_s[1];
    assign ready_s[1]      = wif1.word_ready;

    ccff_bitstream_writer #(.CHAIN_LEN(5), .WORD_W(8)) dut0 (
        .prog_clk(clk), .prog_rst_n(rst_n),
        .start(start_s[0]), .abort(abort_s[0]), .word(wif0),
        .ccff_head(head_s[0]), .ccff_shift_en(en_s[0]),
        .ccff_tail(tail_s[0]), .rb_bit(rbb_s[0]),
        .rb_valid(rbv_s[0]), .busy(busy_s[0]), .done(done_s[0])
    );

    ccff_bitstream_writer #(.CHAIN_LEN(20), .WORD_W(8)) dut1 (
        .prog_clk(clk), .prog_rst_n(rst_n),
        .start(start_s[1]), .abort(abort_s[1]), .word(wif1),
        .ccff_head(head_s[1]), .ccff_shift_en(en_s[1]),
        .ccff_tail(tail_s[1]), .rb_bit(rbb_s[1]),
        .rb_valid(rbv_s[1]), .busy(busy_s[1]), .done(done_s[1])
    );

    // chain models: bit 0 is the tail-most flop
    logic [19:0] chain0, chain1, pre_val;
    logic [1:0]  pre_req;

    always @(posedge clk) begin
        if (pre_req[0]) chain0 <= pre_val;
        else if (en_s[0]) chain0 <= {15'd0, head_s[0], chain0[4:1]};
        if (pre_req[1]) chain1 <= pre_val;
        else if (en_s[1]) chain1 <= {head_s[1], chain1[19:1]};
    end
    assign tail_s = {chain1[0], chain0[0]};

    int checks = 0;
    int failures = 0;
    int shifts [2] = '{0, 0};
    int dones [2] = '{0, 0};
    bit rbq0 [$];
    bit rbq1 [$];
    logic [1:0] en_prev = 2'b00;
    logic rst_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (en_s[i] === 1'b1) shifts[i]++;
            if (done_s[i] === 1'b1) dones[i]++;
            if (rst_n && rst_prev && (en_prev[i] || rbv_s[i]))
                chk("rbv_lag", 32'(rbv_s[i]), 32'(en_prev[i]));
        end
        if (rbv_s[0] === 1'b1) begin
            chk("rb0_pending", 32'(rbq0.size() != 0), 32'd1);
            if (rbq0.size() != 0) chk("rb0_bit", 32'(rbb_s[0]), 32'(rbq0.pop_front()));
        end
        if (rbv_s[1] === 1'b1) begin
            chk("rb1_pending", 32'(rbq1.size() != 0), 32'd1);
            if (rbq1.size() != 0) chk("rb1_bit", 32'(rbb_s[1]), 32'(rbq1.pop_front()));
        end
        en_prev  <= en_s;
        rst_prev <= rst_n;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic preload(input int s, input logic [19:0] v);
        @(negedge clk);
        pre_val = v;
        pre_req[s] = 1'b1;
        @(negedge clk);
        pre_req[s] = 1'b0;
    endtask

    task automatic flush(input int s);
        if (s == 0) rbq0.delete();
        else rbq1.delete();
    endtask

    task automatic begin_load(input int s);
        if (s == 0) for (int i = 0; i < 5; i++) rbq0.push_back(chain0[i]);
        else for (int i = 0; i < 20; i++) rbq1.push_back(chain1[i]);
        start_s[s] = 1'b1;
        @(negedge clk);
        start_s[s] = 1'b0;
    endtask

    task automatic send_word(input int s, input logic [7:0] d, input int gap);
        int k;
        repeat (gap) @(negedge clk);
        data_s[s] = d;
        valid_s[s] = 1'b1;
        k = 0;
        while (!ready_s[s] && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) chk("ready_timeout", 32'(ready_s[s]), 32'd1);
        @(negedge clk);
        valid_s[s] = 1'b0;
    endtask

    task automatic wait_done(input int s);
        int k;
        k = 0;
        while (done_s[s] !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", 32'(done_s[s]), 32'd1);
    endtask

    int s0, d0, seen, k;

    initial begin
        start_s = '0; abort_s = '0; valid_s = '0; pre_req = '0;
        pre_val = '0; data_s[0] = '0; data_s[1] = '0;
        tick(3);
        chk("reset_outs0", {head_s[0], en_s[0], rbb_s[0], rbv_s[0],
            busy_s[0], done_s[0], ready_s[0]}, 32'd0);
        chk("reset_outs1", {head_s[1], en_s[1], rbb_s[1], rbv_s[1],
            busy_s[1], done_s[1], ready_s[1]}, 32'd0);
        rst_n = 1'b1;
        preload(0, 20'd0);
        preload(1, 20'd0);

        // word offered before start is held off
        data_s[0] = 8'h15; valid_s[0] = 1'b1;
        tick(2);
        chk("ready_idle", 32'(ready_s[0]), 32'd0);
        s0 = shifts[0]; d0 = dones[0];
        begin_load(0);
        send_word(0, 8'h15, 0);
        chk("latency_n1", 32'(en_s[0]), 32'd0);
        tick(1);
        chk("latency_n2", 32'(en_s[0]), 32'd1);
        wait_done(0);
        tick(1);
        chk("done_pulse", 32'(done_s[0]), 32'd0);
        chk("shifts_15", 32'(shifts[0] - s0), 32'd5);
        chk("dones_15", 32'(dones[0] - d0), 32'd1);
        chk("chain_15", 32'(chain0[4:0]), 32'h15);
        chk("busy_after", 32'(busy_s[0]), 32'd0);

        // high bits of a word beyond the chain are discarded
        s0 = shifts[0];
        begin_load(0);
        send_word(0, 8'hEA, 1);
        wait_done(0);
        tick(1);
        chk("chain_ea", 32'(chain0[4:0]), 32'h0A);
        chk("shifts_ea", 32'(shifts[0] - s0), 32'd5);

        // readback of preloaded contents, tail first
        preload(0, 20'b11001);
        begin_load(0);
        send_word(0, 8'h00, 2);
        wait_done(0);
        tick(2);
        chk("rb0_drained", 32'(rbq0.size()), 32'd0);
        chk("chain_00", 32'(chain0[4:0]), 32'h00);

        // 20-bit chain, three words with random gaps
        preload(1, 20'h12345);
        s0 = shifts[1]; d0 = dones[1];
        begin_load(1);
        send_word(1, 8'hA5, $urandom_range(0, 3));
        send_word(1, 8'h3C, $urandom_range(0, 3));
        send_word(1, 8'h0F, $urandom_range(0, 3));
        wait_done(1);
        tick(2);
        chk("chain_20", 32'(chain1), 32'hF3CA5);
        chk("shifts_20", 32'(shifts[1] - s0), 32'd20);
        chk("dones_20", 32'(dones[1] - d0), 32'd1);
        chk("rb1_drained", 32'(rbq1.size()), 32'd0);

        // abort after three shifts
        s0 = shifts[1]; d0 = dones[1];
        begin_load(1);
        send_word(1, 8'hFF, 0);
        seen = 0; k = 0;
        while (seen < 3 && k < 50) begin
            @(negedge clk);
            if (en_s[1]) seen++;
            k++;
        end
        abort_s[1] = 1'b1;
        @(negedge clk);
        abort_s[1] = 1'b0;
        chk("abort_en", 32'(en_s[1]), 32'd0);
        chk("abort_busy", 32'(busy_s[1]), 32'd0);
        chk("abort_ready", 32'(ready_s[1]), 32'd0);
        tick(3);
        chk("abort_shifts", 32'(shifts[1] - s0), 32'd3);
        chk("abort_nodone", 32'(dones[1] - d0), 32'd0);
        flush(1);

        // full reload with an ignored start during SHIFT
        s0 = shifts[1]; d0 = dones[1];
        begin_load(1);
        send_word(1, 8'h3C, 0);
        start_s[1] = 1'b1;
        @(negedge clk);
        start_s[1] = 1'b0;
        send_word(1, 8'hC3, 1);
        send_word(1, 8'h5A, 2);
        wait_done(1);
        tick(2);
        chk("reload_chain", 32'(chain1), 32'hAC33C);
        chk("reload_shifts", 32'(shifts[1] - s0), 32'd20);
        chk("reload_dones", 32'(dones[1] - d0), 32'd1);

        // start and abort together in LOAD
        s0 = shifts[1];
        begin_load(1);
        chk("load_ready", 32'(ready_s[1]), 32'd1);
        start_s[1] = 1'b1; abort_s[1] = 1'b1;
        @(negedge clk);
        start_s[1] = 1'b0; abort_s[1] = 1'b0;
        chk("sa_busy", 32'(busy_s[1]), 32'd0);
        chk("sa_ready", 32'(ready_s[1]), 32'd0);
        tick(3);
        chk("sa_shifts", 32'(shifts[1] - s0), 32'd0);
        flush(1);

        // asynchronous reset mid-shift
        begin_load(1);
        send_word(1, 8'h99, 0);
        tick(2);
        chk("pre_reset_en", 32'(en_s[1]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_outs", {head_s[1], en_s[1], rbb_s[1], rbv_s[1],
            busy_s[1], done_s[1], ready_s[1]}, 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("post_rst_busy", 32'(busy_s[1]), 32'd0);
        chk("post_rst_ready", 32'(ready_s[1]), 32'd0);
        s0 = shifts[1];
        tick(5);
        chk("post_rst_shifts", 32'(shifts[1] - s0), 32'd0);
        flush(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
